mem_ldst_unit: RTL and testbench
================================

Name: mem_ldst_unit

Overview:
- Initiator-side load/store unit that issues byte-wide accesses to the 256-byte data RAM.
- Sits between the CPU execute stage and the RAM port. Accepts one request at a time over a valid/ready handshake.
- Sequences 1- or 2-byte little-endian reads/writes onto MemRead/MemWrite/addr/wdata, and returns load data over a valid/ready response channel.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, RAM data width; request/response data are 2*DATA_W.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_len  in  1  0=1 byte, 1=2 bytes
- req_addr  in  ADDR_W  byte address of low byte
- req_wdata  in  2*DATA_W  store data; [7:0] goes to addr, [15:8] to addr+1
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  2*DATA_W  load data, zero-extended for 1-byte loads; 0 for stores
- MemWrite  out  1  RAM write strobe (RAM writes at posedge while high)
- MemRead  out  1  RAM read enable (RAM output is combinational from addr)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, MemWrite=0, MemRead=0, mem_addr=0, mem_wdata=0.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write/len/addr/wdata and go to ACC0.
  - req_ready=0 in every other state.
- ACC0:
  - mem_addr=latched addr.
  - Store: MemWrite=1, mem_wdata=wdata[7:0].
  - Load: MemRead=1, and rsp_rdata[7:0] is captured from mem_rdata at the end of this cycle.
  - Next state: ACC1 if len=1, else RESP.
- ACC1:
  - mem_addr=addr+1, truncated to ADDR_W, so 0xFF wraps to 0x00.
  - Store: MemWrite=1, mem_wdata=wdata[15:8].
  - Load: MemRead=1, and rsp_rdata[15:8] is captured.
  - Next state: RESP.
- RESP:
  - rsp_valid=1; hold rsp_rdata stable until rsp_valid&&rsp_ready.
  - On handshake go to IDLE. The new request is accepted no earlier than the cycle after.
- Outside ACC0/ACC1: MemRead=MemWrite=0, and mem_addr/mem_wdata hold their last values.
- MemRead and MemWrite are never both 1.
- RAM-side outputs are registered, or decoded from registered state only. There is no combinational path from req_* to the RAM port.
- Latency from accept edge to rsp_valid high: 2 cycles for 1-byte access, 3 cycles for 2-byte access.
- Stores also return a response (completion ack) with rsp_rdata=0.
- 1-byte load: rsp_rdata[15:8]=0.
- rsp_rdata is cleared to 0 on entry to ACC0.
- req_valid in a non-IDLE state is ignored and not queued.
- rsp_ready with rsp_valid=0 has no effect.
- Reset mid-operation:
  - At the reset edge, any MemWrite already high is sampled by the RAM at that same edge, so that byte is written.
  - From the following cycle all outputs hold their reset values.
  - No response is produced for the aborted request.

Optional Feature:
- Macro: LDST_WRAP_ERR_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - A 2-byte request with req_addr=2^ADDR_W-1 goes IDLE->RESP directly, with no MemRead/MemWrite strobes, rsp_rdata=0 and rsp_err=1.
  - rsp_err is 0 for all other responses and is valid only with rsp_valid.
- Undefined: no rsp_err port; the address wraps to 0x00 as described under Behaviour.

Test Plan:
- Reset, then 1-byte store 0xA5 to 0x10, then 1-byte load of 0x10 -> store: MemWrite high exactly 1 cycle with mem_addr=0x10; ack 2 cycles after accept. Load: rsp_rdata=0x00A5 2 cycles after accept.
- 2-byte store 0xBEEF to 0x20, then 2-byte load of 0x20 -> RAM[0x20]=0xEF, RAM[0x21]=0xBE; load rsp_rdata=0xBEEF, rsp_valid 3 cycles after accept.
- 2-byte store 0x1234 to 0xFF (macro off) -> RAM[0xFF]=0x34, RAM[0x00]=0x12. With macro on: no strobes, rsp_err=1, RAM unchanged.
- Hold rsp_ready=0 for 5 cycles after load data is ready -> rsp_valid and rsp_rdata stay stable, req_ready=0, a req_valid pulse is ignored. Then rsp_ready=1 -> IDLE next cycle.
- Back-to-back req_valid held high with rsp_ready=1 -> exactly one accept per transaction, and MemRead/MemWrite are never both high.
- Assert rst during ACC1 of a 2-byte store of 0x5566 to 0x40 -> RAM[0x40]=0x66 and RAM[0x41]=0x55 (the ACC1 write coincides with the reset edge); no rsp_valid; req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/mem_ldst_if.sv
// Request/response and RAM-port bundle for mem_ldst_unit.
// The master modport is the CPU/RAM side and the slave modport is the unit; LDST_WRAP_ERR_EN adds rsp_err.
interface mem_ldst_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
    // Once raised, valid holds its payload until that edge.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_len;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_rdata;
    logic                  MemWrite;
    logic                  MemRead;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
`ifdef LDST_WRAP_ERR_EN
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_len, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, MemWrite, MemRead, mem_addr, mem_wdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_len, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, MemWrite, MemRead, mem_addr, mem_wdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_write, req_len, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, MemWrite, MemRead, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_write, req_len, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, MemWrite, MemRead, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_ldst_unit.sv
// Load/store unit issuing 1- or 2-byte little-endian accesses to a byte-wide RAM.
// Optional LDST_WRAP_ERR_EN: 2-byte access at the top address errors out instead of wrapping.
module mem_ldst_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_ldst_if.slave   bus,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                len_q, len_d;
    logic [DATA_W-1:0]   wdata_hi_q, wdata_hi_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                in_access;
`ifdef LDST_WRAP_ERR_EN
    logic                err_q, err_d;
    logic                wrap_req;

    assign wrap_req    = bus.req_len && (bus.req_addr == {ADDR_W{1'b1}});
    assign bus.rsp_err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            len_q       <= 1'b0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef LDST_WRAP_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            len_q       <= len_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LDST_WRAP_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // RAM address/data are loaded one edge ahead of each access cycle so the port is purely registered.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        len_d       = len_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LDST_WRAP_ERR_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    len_d      = bus.req_len;
                    wdata_hi_d = bus.req_wdata[2*DATA_W-1:DATA_W];
                    rdata_d    = '0;
`ifdef LDST_WRAP_ERR_EN
                    err_d      = wrap_req;
                    if (wrap_req) begin
                        state_d = RESP;
                    end else begin
                        state_d    = ACC0;
                        mem_addr_d = bus.req_addr;
                        if (bus.req_write) mem_wdata_d = bus.req_wdata[DATA_W-1:0];
                    end
`else
                    state_d    = ACC0;
                    mem_addr_d = bus.req_addr;
                    if (bus.req_write) mem_wdata_d = bus.req_wdata[DATA_W-1:0];
`endif
                end
            end
            ACC0: begin
                if (!write_q) rdata_d[DATA_W-1:0] = bus.mem_rdata;
                if (len_q) begin
                    state_d    = ACC1;
                    mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (write_q) mem_wdata_d = wdata_hi_q;
                end else begin
                    state_d = RESP;
                end
            end
            ACC1: begin
                if (!write_q) rdata_d[2*DATA_W-1:DATA_W] = bus.mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_access     = (state_q == ACC0) || (state_q == ACC1);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.MemWrite  = in_access && write_q;
    assign bus.MemRead   = in_access && !write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_ldst_unit.sv
// Directed bench for mem_ldst_unit with a behavioural 256-byte RAM.
module tb_mem_ldst_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       ram_init;
  logic [1:0] dbg_state;
  logic [7:0] ram [256];
  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         both_cnt = 0;

  mem_ldst_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_ldst_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // RAM writes on any edge with MemWrite high, including a reset edge.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.MemWrite) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) acc_cnt++;
  end
  always @(negedge clk) begin
    if (bus.MemRead && bus.MemWrite) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic len, input logic [7:0] addr, input logic [15:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_len   = len;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    ram_init = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_len = 1'b0;
    bus.req_addr = 8'h00;
    bus.req_wdata = 16'h0000;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    ram_init = 1'b0;
    rst = 1'b0;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_memwrite", bus.MemWrite, 0);
    chk("rst_memread", bus.MemRead, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_state", dbg_state, 0);

    // 1-byte store 0xA5 to 0x10
    set_req(1'b1, 1'b0, 8'h10, 16'h00A5);
    tick();
    bus.req_valid = 1'b0;
    chk("st1_acc0_memwrite", bus.MemWrite, 1);
    chk("st1_acc0_memread", bus.MemRead, 0);
    chk("st1_acc0_addr", bus.mem_addr, 8'h10);
    chk("st1_acc0_wdata", bus.mem_wdata, 8'hA5);
    chk("st1_acc0_rsp_valid", bus.rsp_valid, 0);
    chk("st1_acc0_req_ready", bus.req_ready, 0);
    tick();
    chk("st1_resp_valid", bus.rsp_valid, 1);
    chk("st1_resp_memwrite", bus.MemWrite, 0);
    chk("st1_resp_rdata", bus.rsp_rdata, 0);
    chk("st1_resp_addr_hold", bus.mem_addr, 8'h10);
    chk("st1_ram10", ram[8'h10], 8'hA5);
    chk("st1_ram11", ram[8'h11], 8'h4B);
    tick();
    chk("st1_idle_ready", bus.req_ready, 1);
    chk("st1_idle_valid", bus.rsp_valid, 0);

    // 1-byte load of 0x10
    set_req(1'b0, 1'b0, 8'h10, 16'hFFFF);
    tick();
    bus.req_valid = 1'b0;
    chk("ld1_acc0_memread", bus.MemRead, 1);
    chk("ld1_acc0_memwrite", bus.MemWrite, 0);
    chk("ld1_acc0_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("ld1_resp_valid", bus.rsp_valid, 1);
    chk("ld1_resp_rdata", bus.rsp_rdata, 16'h00A5);
    chk("ld1_resp_memread", bus.MemRead, 0);
    chk("ld1_ram_intact", ram[8'h10], 8'hA5);
    tick();

    // 2-byte store 0xBEEF to 0x20
    set_req(1'b1, 1'b1, 8'h20, 16'hBEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("st2_acc0_addr", bus.mem_addr, 8'h20);
    chk("st2_acc0_wdata", bus.mem_wdata, 8'hEF);
    chk("st2_acc0_memwrite", bus.MemWrite, 1);
    tick();
    chk("st2_acc1_state", dbg_state, 2);
    chk("st2_acc1_addr", bus.mem_addr, 8'h21);
    chk("st2_acc1_wdata", bus.mem_wdata, 8'hBE);
    chk("st2_acc1_memwrite", bus.MemWrite, 1);
    chk("st2_acc1_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("st2_resp_valid", bus.rsp_valid, 1);
    chk("st2_resp_rdata", bus.rsp_rdata, 0);
    chk("st2_ram20", ram[8'h20], 8'hEF);
    chk("st2_ram21", ram[8'h21], 8'hBE);
    tick();

    // 2-byte load of 0x20
    set_req(1'b0, 1'b1, 8'h20, 16'h0000);
    tick();
    bus.req_valid = 1'b0;
    chk("ld2_acc0_memread", bus.MemRead, 1);
    tick();
    chk("ld2_acc1_memread", bus.MemRead, 1);
    chk("ld2_acc1_addr", bus.mem_addr, 8'h21);
    chk("ld2_acc1_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("ld2_resp_valid", bus.rsp_valid, 1);
    chk("ld2_resp_rdata", bus.rsp_rdata, 16'hBEEF);
    tick();

    // 2-byte store 0x1234 to 0xFF
    set_req(1'b1, 1'b1, 8'hFF, 16'h1234);
    tick();
    bus.req_valid = 1'b0;
`ifdef LDST_WRAP_ERR_EN
    chk("wrap_err_valid", bus.rsp_valid, 1);
    chk("wrap_err_flag", bus.rsp_err, 1);
    chk("wrap_err_memwrite", bus.MemWrite, 0);
    chk("wrap_err_rdata", bus.rsp_rdata, 0);
    tick();
    chk("wrap_err_ramff", ram[8'hFF], 8'hA5);
    chk("wrap_err_ram00", ram[8'h00], 8'h5A);
`else
    chk("wrap_acc0_addr", bus.mem_addr, 8'hFF);
    chk("wrap_acc0_wdata", bus.mem_wdata, 8'h34);
    tick();
    chk("wrap_acc1_addr", bus.mem_addr, 8'h00);
    chk("wrap_acc1_wdata", bus.mem_wdata, 8'h12);
    tick();
    chk("wrap_resp_valid", bus.rsp_valid, 1);
    chk("wrap_ramff", ram[8'hFF], 8'h34);
    chk("wrap_ram00", ram[8'h00], 8'h12);
    tick();
`endif
    chk("wrap_idle", bus.req_ready, 1);

    // Back-pressure: 1-byte load of 0x21 with rsp_ready low
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 8'h21, 16'h0000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_rdata", bus.rsp_rdata, 16'h00BE);
      chk("bp_req_ready", bus.req_ready, 0);
      if (i == 1) set_req(1'b1, 1'b0, 8'h30, 16'hFFFF);
      if (i == 2) bus.req_valid = 1'b0;
      tick();
    end
    chk("bp_still_valid", bus.rsp_valid, 1);
    chk("bp_no_strobe", bus.MemWrite, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", bus.req_ready, 1);
    chk("bp_idle_valid", bus.rsp_valid, 0);
    chk("bp_ram30", ram[8'h30], 8'h6A);

    // Back-to-back: req_valid held high for 12 cycles of 1-byte loads
    acc_cnt = 0;
    both_cnt = 0;
    set_req(1'b0, 1'b0, 8'h20, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i % 3 == 1) chk("b2b_rdata", bus.rsp_rdata, 16'h00EF);
      if (i % 3 == 1) chk("b2b_valid", bus.rsp_valid, 1);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_accepts", acc_cnt, 4);
    chk("b2b_both_strobes", both_cnt, 0);

    // Reset during ACC1 of 2-byte store 0x5566 to 0x40
    set_req(1'b1, 1'b1, 8'h40, 16'h5566);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rmid_acc1_state", dbg_state, 2);
    rst = 1'b1;
    tick();
    chk("rmid_rsp_valid", bus.rsp_valid, 0);
    chk("rmid_req_ready", bus.req_ready, 1);
    chk("rmid_memwrite", bus.MemWrite, 0);
    chk("rmid_mem_addr", bus.mem_addr, 0);
    chk("rmid_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    chk("rmid_ram40", ram[8'h40], 8'h66);
    chk("rmid_ram41", ram[8'h41], 8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_no_rsp", bus.rsp_valid, 0);
    end
    chk("rmid_idle_ready", bus.req_ready, 1);
    chk("b2b_final_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
